// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// frame width, default oversampling ratio and a 2-of-3 vote helper.
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input, plus the
// previous-value register used to detect a falling edge of the synced line.
// Everything resets to 1 so a line that idles high never looks like an edge.
module rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rxd,
    output logic rxd_s,
    output logic rxd_fall
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Metastability chain and one-cycle history of the synced line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q1 <= rxd;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign rxd_s    = sync_q2;
    assign rxd_fall = prev_q & ~sync_q2;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1, LSB first, oversampled by an external tick.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote over the
// three ticks ending at the sample point instead of a single sample.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for a 1->0 edge on the synced input
// START | counting to mid start bit; a 1 there is a false start
// DATA  | sampling 8 data bits at mid-bit, shifting in from the MSB
// STOP  | sampling the stop bit; strobe valid or framing error, then IDLE
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int              SW       = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0]   MID_PT   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]   FULL_PT  = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [SW-1:0]        s_cnt;
    logic [2:0]           b_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rxd_s;
    logic                 rxd_fall;
    logic                 at_point;
    logic                 sample_pt;
    logic                 bit_val;
    logic                 valid_set;
    logic                 err_set;

    rx_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .rxd      (rxd),
        .rxd_s    (rxd_s),
        .rxd_fall (rxd_fall)
    );

    // Start bit is judged at its middle; data and stop bits one full period later.
    assign at_point  = (state == START) ? (s_cnt == MID_PT) : (s_cnt == FULL_PT);
    assign sample_pt = tick && (state != IDLE) && at_point;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Keep the synced line from the two previous ticks for the vote.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q <= 2'b11;
        end else if (tick) begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign bit_val = maj3(hist_q[1], hist_q[0], rxd_s);
`else
    assign bit_val = rxd_s;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rxd_fall) state_nxt = START;
            START:   if (sample_pt) state_nxt = bit_val ? IDLE : DATA;
            DATA:    if (sample_pt && (b_cnt == LAST_BIT)) state_nxt = STOP;
            STOP:    if (sample_pt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: busy level and the strobe requests for the stop-bit sample.
    always_comb begin
        rx_busy   = (state != IDLE);
        valid_set = 1'b0;
        err_set   = 1'b0;
        if ((state == STOP) && sample_pt) begin
            valid_set = bit_val;
            err_set   = ~bit_val;
        end
    end

    // Tick/bit counters, shift register and registered output strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_cnt     <= '0;
            b_cnt     <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= valid_set;
            frame_err <= err_set;
            if (valid_set) begin
                rx_data <= shift_q;
            end
            case (state)
                IDLE: begin
                    // The tick coinciding with the edge is deliberately not counted.
                    if (rxd_fall) begin
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (sample_pt) begin
                        s_cnt <= '0;
                        b_cnt <= '0;
                    end else if (tick) begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_pt) begin
                        s_cnt   <= '0;
                        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                        if (b_cnt != LAST_BIT) begin
                            b_cnt <= b_cnt + 1'b1;
                        end
                    end else if (tick) begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (sample_pt) begin
                        s_cnt <= '0;
                    end else if (tick) begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                default: begin
                    s_cnt <= '0;
                end
            endcase
        end
    end

endmodule
